// File: rtl/fetch_unit.sv
// Fetch-stage front end: owns the PC, runs a single-outstanding request/response
// handshake with instruction memory, and presents InstrF/PCF/PCPlus4F to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        BusyF
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        req_c;
    logic [31:0] addr_c;

    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = PCSrcE ? PCTargetE : pc_plus4;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_c   = 1'b0;
        addr_c  = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (PCSrcE) begin
                    pc_d = next_pc;
                end else begin
                    req_c   = 1'b1;
                    addr_c  = pc_q;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (imem_valid) begin
                    if (PCSrcE) begin
                        pc_d    = next_pc;
                        state_d = IDLE;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (PCSrcE) begin
                    pc_d    = next_pc;
                    state_d = DISCARD;
                end
            end

            HOLD: begin
                // A redirect kills the held instruction even while decode stalls.
                if (PCSrcE) begin
                    pc_d    = next_pc;
                    instr_d = NOP;
                    state_d = IDLE;
                end else if (!StallF) begin
                    pc_d    = next_pc;
                    req_c   = 1'b1;
                    addr_c  = pc_plus4;
                    state_d = WAIT;
                end
            end

            DISCARD: begin
                if (PCSrcE) begin
                    pc_d = next_pc;
                end
                if (imem_valid) begin
                    state_d = IDLE;
                end
            end

            default: ;
        endcase
    end

    // The request is suppressed while reset is held, whatever state it interrupts.
    assign imem_req  = req_c & ~reset;
    assign imem_addr = reset ? 32'd0 : addr_c;

    assign PCF      = pc_q;
    assign PCPlus4F = pc_plus4;
    assign InstrF   = (state_q == HOLD) ? instr_q : NOP;
    assign BusyF    = (state_q != HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table for the corner cases, then
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        BusyF;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_valid(imem_valid),
        .imem_rdata(imem_rdata),
        .InstrF    (InstrF),
        .PCF       (PCF),
        .PCPlus4F  (PCPlus4F),
        .BusyF     (BusyF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        vld;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic src,
                                input logic [31:0] tgt, input logic vld, input logic [31:0] rd,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic e_busy);
        vec_t v;
        v.rst = rst; v.stall = stall; v.src = src; v.tgt = tgt; v.vld = vld; v.rdata = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a PC, an optional held instruction, and an optional
    // outstanding request that may have been made stale by a redirect.
    logic [31:0] m_pc, m_instr;
    bit          m_have, m_out, m_stale;

    task automatic model_expect(output logic e_req, output logic [31:0] e_addr);
        e_req  = 1'b0;
        e_addr = 32'd0;
        if (!reset && !PCSrcE) begin
            if (!m_out && !m_have) begin
                e_req  = 1'b1;
                e_addr = m_pc;
            end else if (m_have && !StallF) begin
                e_req  = 1'b1;
                e_addr = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_pc = RESET_PC; m_have = 0; m_out = 0; m_stale = 0;
        end else if (m_out) begin
            if (imem_valid) begin
                m_out = 0;
                if (!m_stale && !PCSrcE) begin
                    m_have  = 1;
                    m_instr = imem_rdata;
                end
                m_stale = 0;
            end else if (PCSrcE) begin
                m_stale = 1;
            end
            if (PCSrcE) m_pc = PCTargetE;
        end else if (m_have) begin
            if (PCSrcE) begin
                m_have = 0;
                m_pc   = PCTargetE;
            end else if (!StallF) begin
                m_have = 0;
                m_pc   = m_pc + 32'd4;
                m_out  = 1;
            end
        end else begin
            if (PCSrcE) m_pc = PCTargetE;
            else        m_out = 1;
        end
    endtask

    initial begin
        logic        er;
        logic [31:0] ea;
        bit          pending;
        int          cnt;
        bit          deliver;

        reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);

        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,                 0,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h0050_0093,         0,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h4,32'h0050_0093,32'h0,0));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h00A0_0113,         0,32'h0,NOP,32'h4,1));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h00A0_0113,32'h4,0));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h00A0_0113,32'h4,0));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h00A0_0113,32'h4,0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h8,32'h00A0_0113,32'h4,0));
        vecs.push_back(mk(0,0,1,32'h100,0,32'h0,               0,32'h0,NOP,32'h8,1));
        vecs.push_back(mk(0,0,1,32'h180,0,32'h0,               0,32'h0,NOP,32'h100,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'hDEAD_BEEF,         0,32'h0,NOP,32'h180,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h180,NOP,32'h180,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h1111_1111,         0,32'h0,NOP,32'h180,1));
        vecs.push_back(mk(0,1,1,32'h40,0,32'h0,                0,32'h0,32'h1111_1111,32'h180,0));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 1,32'h40,NOP,32'h40,1));
        vecs.push_back(mk(0,0,1,32'h200,1,32'h2222_2222,       0,32'h0,NOP,32'h40,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h200,NOP,32'h200,1));
        vecs.push_back(mk(1,0,0,32'h0,0,32'h0,                 0,32'h0,NOP,32'h200,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h3333_3333,         1,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 0,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h4444_4444,         0,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h4444_4444,32'h0,0));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,32'h0,         0,32'h0,32'h4444_4444,32'h0,0));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'hFFFF_FFFC,NOP,32'hFFFF_FFFC,1));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h5555_5555,         0,32'h0,NOP,32'hFFFF_FFFC,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h0,32'h5555_5555,32'hFFFF_FFFC,0));
        vecs.push_back(mk(0,0,0,32'h0,1,32'h6666_6666,         0,32'h0,NOP,32'h0,1));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h6666_6666,32'h0,0));
        vecs.push_back(mk(0,1,0,32'h0,1,32'h7777_7777,         0,32'h0,32'h6666_6666,32'h0,0));
        vecs.push_back(mk(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h6666_6666,32'h0,0));
        vecs.push_back(mk(0,0,1,32'h300,0,32'h0,               0,32'h0,32'h6666_6666,32'h0,0));
        vecs.push_back(mk(0,0,1,32'h400,0,32'h0,               0,32'h0,NOP,32'h300,1));
        vecs.push_back(mk(0,0,0,32'h0,0,32'h0,                 1,32'h400,NOP,32'h400,1));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; StallF = vecs[i].stall; PCSrcE = vecs[i].src;
            PCTargetE = vecs[i].tgt; imem_valid = vecs[i].vld; imem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("vec%0d.req", i),   {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            check($sformatf("vec%0d.addr", i),  imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d.instr", i), InstrF, vecs[i].e_instr);
            check($sformatf("vec%0d.pc", i),    PCF, vecs[i].e_pc);
            check($sformatf("vec%0d.pc4", i),   PCPlus4F, vecs[i].e_pc + 32'd4);
            check($sformatf("vec%0d.busy", i),  {31'd0, BusyF}, {31'd0, vecs[i].e_busy});
        end

        // Randomized phase, starting from a clean reset so the model is in step.
        @(negedge clk);
        reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; imem_valid = 1'b0;
        @(posedge clk);
        model_step();
        pending = 0;
        cnt     = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            reset  = ($urandom_range(0, 149) == 0);
            StallF = ($urandom_range(0, 2) == 0);
            PCSrcE = ($urandom_range(0, 9) == 0);
            PCTargetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            deliver    = pending && (cnt == 0);
            imem_valid = deliver || (!pending && $urandom_range(0, 19) == 0);
            imem_rdata = $urandom();
            #1;
            model_expect(er, ea);
            check("rnd.req",   {31'd0, imem_req}, {31'd0, er});
            check("rnd.addr",  imem_addr, ea);
            check("rnd.instr", InstrF, m_have ? m_instr : NOP);
            check("rnd.pc",    PCF, m_pc);
            check("rnd.pc4",   PCPlus4F, m_pc + 32'd4);
            check("rnd.busy",  {31'd0, BusyF}, {31'd0, !m_have});
            @(posedge clk);
            model_step();
            if (reset) begin
                pending = 0;
            end else begin
                if (deliver)      pending = 0;
                else if (pending) cnt--;
                if (er) begin
                    pending = 1;
                    cnt     = $urandom_range(0, 2);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch-stage front end that produces InstrF, PCF and PCPlus4F for the fetch/decode pipeline register. It owns the PC register and runs a single-outstanding request/response handshake with instruction memory. It honours StallF from the hazard unit, takes redirects from execute (PCSrcE/PCTargetE), and drops in-flight fetches made stale by a redirect. While no valid instruction is held, it presents a NOP bubble and raises BusyF.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP, 32'h0000_0013, instruction word driven while no valid instruction is held (addi x0,x0,0)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hazard-unit stall; 1 = decode not accepting, hold current instruction
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  32  redirect target
- imem_req  out  1  one-cycle request strobe
- imem_addr  out  32  request address, valid when imem_req=1
- imem_valid  in  1  response strobe, one cycle per request
- imem_rdata  in  32  response data, valid with imem_valid
- InstrF  out  32  fetched instruction or NOP
- PCF  out  32  PC of InstrF
- PCPlus4F  out  32  PCF + 4, mod 2^32
- BusyF  out  1  1 = no valid instruction held; InstrF is NOP

## Operation
- Registers: pc_q (32 bits), instr_q (32 bits), state ∈ {IDLE, WAIT, HOLD, DISCARD}.
- Outputs are combinational from the registers:
  - PCF = pc_q; PCPlus4F = pc_q + 4 (wraps at 2^32).
  - InstrF = instr_q in HOLD, otherwise NOP.
  - BusyF = 0 only in HOLD.
- next_pc = PCTargetE if PCSrcE, else pc_q + 4.
- **IDLE**
  - PCSrcE=0: imem_req=1, imem_addr=pc_q, go to WAIT.
  - PCSrcE=1: no request; pc_q←PCTargetE; stay in IDLE.
  - StallF is ignored.
- **WAIT**
  - imem_req=0 throughout.
  - imem_valid & !PCSrcE: instr_q←imem_rdata, go to HOLD.
  - imem_valid & PCSrcE: drop data, pc_q←PCTargetE, go to IDLE.
  - !imem_valid & PCSrcE: pc_q←PCTargetE, go to DISCARD.
- **HOLD**
  - PCSrcE=1 (wins over StallF): drop instr_q, pc_q←PCTargetE, no request, go to IDLE.
  - StallF=1: everything held, no request.
  - StallF=0: the instruction is consumed this edge. pc_q←pc_q+4; imem_req=1 with imem_addr=pc_q+4 in the same cycle; go to WAIT.
- **DISCARD**
  - Waits for the stale response. imem_req=0.
  - imem_valid: drop data, go to IDLE.
  - PCSrcE=1: pc_q←PCTargetE, regardless of imem_valid.
- imem_valid in IDLE or HOLD is ignored (protocol violation; must not corrupt state).
- At most one request is ever outstanding. imem_req is never asserted in WAIT or DISCARD.
- imem_addr = 0 when imem_req=0.

## Timing
- Reset values:
  - state=IDLE, pc_q=RESET_PC, instr_q=NOP.
  - BusyF=1, InstrF=NOP, PCF=RESET_PC, PCPlus4F=RESET_PC+4.
  - imem_req=0 during the reset cycle.
- First request: imem_req=1 with addr RESET_PC in the first cycle after reset deasserts.
- Memory latency is ≥1 cycle: imem_valid arrives no earlier than the cycle after imem_req.
- With 1-cycle memory and no stalls:
  - req at t, valid at t+1, HOLD at t+2 (instruction visible), next req at t+2.
  - Steady state: one valid instruction every 2 cycles, with a NOP bubble (BusyF=1) between them.
- Redirect latency:
  - PCSrcE at cycle t, request for PCTargetE at t+1 when no response is outstanding.
  - Otherwise the request goes out the cycle after the stale response arrives.
- Reset mid-operation (any state) returns to reset values at the next edge. A response to a pre-reset request arrives in IDLE and is ignored.
- PC wrap: pc_q=32'hFFFF_FFFC gives PCPlus4F=0, and the next fetch goes to address 0.

## Test plan
- Reset, 1-cycle memory returning 32'h00500093 → req addr 0 in cycle 1; HOLD in cycle 3 with InstrF=32'h00500093, PCF=0, PCPlus4F=4, BusyF=0; next req addr 4 in the same cycle.
- HOLD with StallF=1 for 3 cycles → InstrF/PCF stable and no imem_req; StallF drops → req addr PCF+4 in that cycle.
- Redirect during WAIT (PCSrcE=1, PCTargetE=32'h100, response 2 cycles later) → enter DISCARD, stale data never appears on InstrF, next req addr 32'h100, BusyF=1 throughout.
- Redirect and StallF together in HOLD, PCTargetE=32'h40 → instr_q dropped, BusyF=1 next cycle, req addr 32'h40 the cycle after.
- imem_valid and PCSrcE in the same WAIT cycle → data dropped, IDLE, req to the target on the following cycle.
- Reset asserted in WAIT, response arriving one cycle after reset deasserts → ignored; req addr RESET_PC issued; no spurious HOLD.
